intr_ctrl: RTL and testbench

// - Interrupt request controller directly upstream of the CSR unit: collects external sources (DMA done, accelerator done, etc.).
// - Synchronises and edge-detects the sources, latches them as pending, and prioritises them.
// - Drives the single machine-external `interrupt` line consumed by the CSR/PC logic, and retires the request on mret.

---
 rtl/cpu_pkg.sv | 13 +
 rtl/irq_sync.sv | 29 ++
 rtl/intr_ctrl.sv | 103 ++++++++++
 tb/tb_intr_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared core-side types: interrupt controller FSM encoding and the CSR bit
// position of mie.MEIE.
package cpu_pkg;

  typedef enum logic [1:0] {
    IC_IDLE,
    IC_REQ,
    IC_SERV
  } ic_state_e;

  localparam int MEIE_BIT = 11;

endpackage

// File: rtl/irq_sync.sv
// Per-source synchroniser and rising-edge detector; rise fires one cycle per
// synchronised 0->1 transition, SYNC_STAGES+1 clocks after the raw edge.
module irq_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic irq_raw,
  output logic sync_lvl,
  output logic rise
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   sync_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      chain  <= '0;
      sync_d <= 1'b0;
    end else begin
      chain  <= {chain[SYNC_STAGES-2:0], irq_raw};
      sync_d <= chain[SYNC_STAGES-1];
    end
  end

  assign sync_lvl = chain[SYNC_STAGES-1];
  assign rise     = sync_lvl & ~sync_d;

endmodule

// File: rtl/intr_ctrl.sv
// Machine-external interrupt controller: latches source edges as pending, grants
// the lowest enabled index, holds the request until acked and retires it on mret.
module intr_ctrl
  import cpu_pkg::*;
#(
  parameter  int NSRC        = 4,
  parameter  int SYNC_STAGES = 2,
  localparam int IDW         = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [NSRC-1:0] irq_src,
  input  logic [NSRC-1:0] src_en,
  input  logic            meie,
  input  logic            intr_ack,
  input  logic            mret,
  output logic            interrupt,
  output logic [IDW-1:0]  intr_id,
  output logic [NSRC-1:0] pending,
  output logic            wake
);

  function automatic logic [IDW-1:0] pick_lowest(input logic [NSRC-1:0] req);
    logic [IDW-1:0] id;
    id = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (req[i]) id = IDW'(i);
    end
    return id;
  endfunction

  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] cand;
  logic            any_cand;
  logic [IDW-1:0]  winner;
  logic [NSRC-1:0] pend_nxt;
  logic            claim;
  logic            requeue;
  logic            int_nxt;

  ic_state_e state, state_nxt;

  for (genvar g = 0; g < NSRC; g++) begin : g_sync
    irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk      (clk),
      .resetn   (resetn),
      .irq_raw  (irq_src[g]),
      .sync_lvl (),
      .rise     (rise[g])
    );
  end

  assign cand     = pending & src_en;
  assign any_cand = |cand;
  assign winner   = pick_lowest(cand);
  assign wake     = any_cand;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IC_IDLE;
    else         state <= state_nxt;
  end

  // An ack in the same cycle as meie falling wins: the core has already redirected.
  always_comb begin
    state_nxt = state;
    case (state)
      IC_IDLE: if (meie && any_cand) state_nxt = IC_REQ;
      IC_REQ: begin
        if (intr_ack)  state_nxt = IC_SERV;
        else if (!meie) state_nxt = IC_IDLE;
      end
      IC_SERV: if (mret) state_nxt = IC_IDLE;
      default: state_nxt = IC_IDLE;
    endcase
  end

  always_comb begin
    claim   = (state == IC_IDLE) && meie && any_cand;
    requeue = (state == IC_REQ) && !intr_ack && !meie;
    int_nxt = (state == IC_REQ) && !intr_ack && meie;
  end

  // Edge set is applied last so a collision with claim/requeue leaves the bit set.
  always_comb begin
    pend_nxt = pending;
    if (claim)   pend_nxt[winner]  = 1'b0;
    if (requeue) pend_nxt[intr_id] = 1'b1;
    pend_nxt = pend_nxt | rise;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pending   <= '0;
      interrupt <= 1'b0;
      intr_id   <= '0;
    end else begin
      pending   <= pend_nxt;
      interrupt <= int_nxt;
      if (claim) intr_id <= winner;
    end
  end

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed bench for intr_ctrl: a cycle model derived from the behavioural rules
// is compared every cycle, plus literal checks on the key scenarios.
module tb_intr_ctrl;

  localparam int S = 2;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [3:0] irq_src = '0;
  logic [3:0] src_en = 4'hF;
  logic       meie = 1'b1;
  logic       intr_ack = 1'b0;
  logic       mret = 1'b0;
  logic       interrupt;
  logic [1:0] intr_id;
  logic [3:0] pending;
  logic       wake;

  int tests = 0;
  int fails = 0;
  bit chk_on = 1'b0;

  intr_ctrl #(.NSRC(4), .SYNC_STAGES(S)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .irq_src   (irq_src),
    .src_en    (src_en),
    .meie      (meie),
    .intr_ack  (intr_ack),
    .mret      (mret),
    .interrupt (interrupt),
    .intr_id   (intr_id),
    .pending   (pending),
    .wake      (wake)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lowest(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction

  // Model: history of raw samples, pending set, and a mode 0=idle 1=req 2=serv.
  logic [3:0] sh [0:S+1];
  logic [3:0] m_pend = '0;
  logic [1:0] m_id = '0;
  logic       m_int = 1'b0;
  int         m_mode = 0;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k <= S + 1; k++) sh[k] = '0;
      m_pend = '0;
      m_id   = '0;
      m_int  = 1'b0;
      m_mode = 0;
    end else begin
      logic [3:0] redge;
      logic [3:0] cand;
      for (int k = S + 1; k > 0; k--) sh[k] = sh[k-1];
      sh[0] = irq_src;
      redge = sh[S] & ~sh[S+1];
      cand  = m_pend & src_en;
      m_int = 1'b0;
      if (m_mode == 0) begin
        if (meie && cand != 0) begin
          m_id = 2'(lowest(cand));
          m_pend[m_id] = 1'b0;
          m_mode = 1;
        end
      end else if (m_mode == 1) begin
        if (intr_ack) m_mode = 2;
        else if (!meie) begin
          m_pend[m_id] = 1'b1;
          m_mode = 0;
        end else m_int = 1'b1;
      end else if (mret) begin
        m_mode = 0;
      end
      m_pend = m_pend | redge;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("model_interrupt", 32'(interrupt), 32'(m_int));
      chk("model_intr_id",   32'(intr_id),   32'(m_id));
      chk("model_pending",   32'(pending),   32'(m_pend));
      chk("model_wake",      32'(wake),      32'(|(m_pend & src_en)));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic tickn(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_ack();
    intr_ack = 1'b1;
    tick();
    intr_ack = 1'b0;
  endtask

  task automatic do_mret();
    mret = 1'b1;
    tick();
    mret = 1'b0;
  endtask

  initial begin
    for (int k = 0; k <= S + 1; k++) sh[k] = '0;
    tick();
    chk_on = 1'b1;
    chk("reset_interrupt", 32'(interrupt), 0);
    chk("reset_pending",   32'(pending),   0);
    chk("reset_intr_id",   32'(intr_id),   0);
    chk("reset_wake",      32'(wake),      0);
    resetn = 1'b1;
    tick();

    // Single source: interrupt high at clock 5 after the rise.
    irq_src = 4'b0100;
    tickn(3);
    chk("single_pend_c3", 32'(pending), 32'h4);
    chk("single_wake_c3", 32'(wake), 1);
    tick();
    chk("single_int_c4", 32'(interrupt), 0);
    tick();
    chk("single_int_c5", 32'(interrupt), 1);
    chk("single_id_c5",  32'(intr_id), 2);
    chk("single_pend_c5", 32'(pending), 0);
    irq_src = '0;
    do_ack();
    chk("single_int_after_ack", 32'(interrupt), 0);
    tickn(2);
    do_mret();
    tick();
    chk("single_id_hold", 32'(intr_id), 2);
    chk("single_idle_int", 32'(interrupt), 0);

    // Priority: 3 and 1 together, 1 first.
    irq_src = 4'b1010;
    tickn(5);
    chk("prio_int", 32'(interrupt), 1);
    chk("prio_id1", 32'(intr_id), 1);
    chk("prio_pend", 32'(pending), 32'h8);
    irq_src = '0;
    do_ack();
    tickn(2);
    do_mret();
    chk("prio_mret_int", 32'(interrupt), 0);
    tick();
    chk("prio_id3_claim", 32'(intr_id), 3);
    chk("prio_pend_clr", 32'(pending), 0);
    tick();
    chk("prio_int3", 32'(interrupt), 1);
    do_ack();
    do_mret();
    tick();

    // Gating by meie.
    meie = 1'b0;
    irq_src = 4'b0001;
    tickn(3);
    chk("gate_pend", 32'(pending), 1);
    chk("gate_wake", 32'(wake), 1);
    irq_src = '0;
    tickn(4);
    chk("gate_int_low", 32'(interrupt), 0);
    meie = 1'b1;
    tickn(2);
    chk("gate_int", 32'(interrupt), 1);
    chk("gate_id", 32'(intr_id), 0);
    do_ack();
    do_mret();
    tick();

    // meie falls while requesting: request goes back to pending.
    irq_src = 4'b0010;
    tickn(5);
    chk("drop_int_before", 32'(interrupt), 1);
    irq_src = '0;
    meie = 1'b0;
    tick();
    chk("drop_int", 32'(interrupt), 0);
    chk("drop_pend", 32'(pending), 32'h2);
    meie = 1'b1;
    tickn(2);
    chk("drop_reint", 32'(interrupt), 1);
    chk("drop_reid", 32'(intr_id), 1);
    chk("drop_repend", 32'(pending), 0);
    do_ack();
    do_mret();
    tick();

    // Collision: new edge on src 0 lands on the cycle src 0 is claimed.
    meie = 1'b0;
    irq_src = 4'b0001;
    tickn(3);
    irq_src = '0;
    tickn(4);
    irq_src = 4'b0001;
    tickn(2);
    meie = 1'b1;
    tick();
    chk("coll_pend", 32'(pending), 1);
    tick();
    chk("coll_int1", 32'(interrupt), 1);
    irq_src = '0;
    do_ack();
    do_mret();
    tick();
    tick();
    chk("coll_int2", 32'(interrupt), 1);
    chk("coll_id2", 32'(intr_id), 0);
    chk("coll_pend2", 32'(pending), 0);
    do_ack();

    // Reset in SERV with another request pending.
    irq_src = 4'b1000;
    tickn(3);
    irq_src = '0;
    chk("rst_pre_pend", 32'(pending), 32'h8);
    resetn = 1'b0;
    #1;
    chk("rst_int", 32'(interrupt), 0);
    chk("rst_pend", 32'(pending), 0);
    chk("rst_wake", 32'(wake), 0);
    chk("rst_id", 32'(intr_id), 0);
    tick();
    resetn = 1'b1;
    do_mret();
    do_ack();
    tickn(3);
    chk("rst_post_int", 32'(interrupt), 0);
    chk("rst_post_pend", 32'(pending), 0);

    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
